// File: rtl/sudoku_input_ctrl.sv
// sudoku_input_ctrl: turns raw board buttons/switches into clean
// single-cycle commands for the 4x4 sudoku game core.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   btn_up/down        raw buttons -> row_sel[0]/[1] pulses
//   btn_left/right     raw buttons -> col_sel[0]/[1] pulses
//   btn_enter/clear    raw buttons -> enter/clear pulses
//   btn_new            raw button  -> new_game pulse
//   sw_num[3:0]        raw number switches, captured into num_in on enter
//   row_sel/col_sel    direction pulses, bits [3:2] always 0
//   num_in             number presented with enter, held between enters
//   enter/clear/new_game  one-cycle action pulses, one at a time
//
// Optional feature: define SUDOKU_AUTOREPEAT_EN to give the four
// direction buttons hold-to-repeat behaviour.

module sudoku_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000,
    parameter int RPT_W           = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic       btn_new,
    input  logic [3:0] sw_num,
    output logic [3:0] row_sel,
    output logic [3:0] col_sel,
    output logic [3:0] num_in,
    output logic       enter,
    output logic       clear,
    output logic       new_game
);

    // Button index: 0 up, 1 down, 2 left, 3 right, 4 enter, 5 clear, 6 new
    localparam int NB = 7;
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]    raw;
    logic [NB-1:0]    s1_q;
    logic [NB-1:0]    s2_q;
    logic [NB-1:0]    deb_q;
    logic [NB-1:0]    deb_d;
    logic [NB-1:0]    prev_q;
    logic [NB-1:0]    press;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [3:0]       sw_s1_q;
    logic [3:0]       sw_s2_q;

    logic [3:0] dir_ev;
    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;
    logic       enter_q, enter_d;
    logic       clear_q, clear_d;
    logic       new_q, new_d;
    logic [3:0] num_q, num_d;
    // pending action flags: [0] enter, [1] clear, [2] new
    logic [2:0] pend_q, pend_d;
    logic [2:0] act_eff;

    assign raw = {btn_new, btn_clear, btn_enter,
                  btn_right, btn_left, btn_down, btn_up};

    // Debounce: count consecutive mismatching cycles, flip on the last one.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_MAX) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb_q & ~prev_q;

`ifdef SUDOKU_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        R_IDLE,
        R_DELAY,
        R_REPEAT
    } rpt_e;

    localparam logic [RPT_W-1:0] DLY_MAX  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_MAX = RPT_W'(REPEAT_RATE - 1);

    rpt_e             st_q [4];
    rpt_e             st_d [4];
    logic [RPT_W-1:0] rc_q [4];
    logic [RPT_W-1:0] rc_d [4];
    logic [3:0]       rpt_ev;

    always_comb begin
        rpt_ev = '0;
        for (int i = 0; i < 4; i++) begin
            st_d[i] = st_q[i];
            rc_d[i] = rc_q[i];
            unique case (st_q[i])
                R_IDLE: begin
                    if (press[i]) begin
                        st_d[i] = R_DELAY;
                        rc_d[i] = '0;
                    end
                end
                R_DELAY: begin
                    if (!deb_q[i]) begin
                        st_d[i] = R_IDLE;
                        rc_d[i] = '0;
                    end else if (rc_q[i] == DLY_MAX) begin
                        rpt_ev[i] = 1'b1;
                        st_d[i]   = R_REPEAT;
                        rc_d[i]   = '0;
                    end else begin
                        rc_d[i] = rc_q[i] + 1'b1;
                    end
                end
                R_REPEAT: begin
                    if (!deb_q[i]) begin
                        st_d[i] = R_IDLE;
                        rc_d[i] = '0;
                    end else if (rc_q[i] == RATE_MAX) begin
                        rpt_ev[i] = 1'b1;
                        rc_d[i]   = '0;
                    end else begin
                        rc_d[i] = rc_q[i] + 1'b1;
                    end
                end
                default: begin
                    st_d[i] = R_IDLE;
                    rc_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i] <= R_IDLE;
                rc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                st_q[i] <= st_d[i];
                rc_q[i] <= rc_d[i];
            end
        end
    end

    assign dir_ev = press[3:0] | rpt_ev;
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{RPT_W[0], REPEAT_DELAY[0], REPEAT_RATE[0]};
    assign dir_ev = press[3:0];
`endif

    // Directions: opposite events in one cycle cancel.
    // Actions: new_game > enter > clear, new_game flushes the rest.
    always_comb begin
        row_d   = {dir_ev[1] & ~dir_ev[0], dir_ev[0] & ~dir_ev[1]};
        col_d   = {dir_ev[3] & ~dir_ev[2], dir_ev[2] & ~dir_ev[3]};
        act_eff = pend_q | {press[6], press[5], press[4]};
        new_d   = act_eff[2];
        enter_d = act_eff[0] & ~act_eff[2];
        clear_d = act_eff[1] & ~act_eff[0] & ~act_eff[2];
        pend_d  = act_eff & ~{new_d, clear_d, enter_d};
        if (new_d) begin
            pend_d = '0;
        end
        num_d = enter_d ? sw_s2_q : num_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            deb_q   <= '0;
            prev_q  <= '0;
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            row_q   <= '0;
            col_q   <= '0;
            enter_q <= 1'b0;
            clear_q <= 1'b0;
            new_q   <= 1'b0;
            num_q   <= '0;
            pend_q  <= '0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            prev_q  <= deb_q;
            sw_s1_q <= sw_num;
            sw_s2_q <= sw_s1_q;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            row_q   <= row_d;
            col_q   <= col_d;
            enter_q <= enter_d;
            clear_q <= clear_d;
            new_q   <= new_d;
            num_q   <= num_d;
            pend_q  <= pend_d;
        end
    end

    assign row_sel  = {2'b00, row_q};
    assign col_sel  = {2'b00, col_q};
    assign num_in   = num_q;
    assign enter    = enter_q;
    assign clear    = clear_q;
    assign new_game = new_q;

endmodule

// File: tb/tb_sudoku_input_ctrl.sv
// Testbench for sudoku_input_ctrl with short debounce/repeat timing.
// Table of single-press vectors plus hand sequences for corner cases.

module tb_sudoku_input_ctrl;

`ifdef SUDOKU_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       btn_enter, btn_clear, btn_new;
    logic [3:0] sw_num;
    logic [3:0] row_sel, col_sel, num_in;
    logic       enter, clear, new_game;

    always #5 clk = ~clk;

    sudoku_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(20),
        .REPEAT_DELAY(20),
        .REPEAT_RATE(5),
        .RPT_W(26)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_enter(btn_enter),
        .btn_clear(btn_clear),
        .btn_new(btn_new),
        .sw_num(sw_num),
        .row_sel(row_sel),
        .col_sel(col_sel),
        .num_in(num_in),
        .enter(enter),
        .clear(clear),
        .new_game(new_game)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // bits: 0 up, 1 down, 2 left, 3 right, 4 enter, 5 clear, 6 new
    task automatic set_btn(input logic [6:0] m);
        btn_up    = m[0];
        btn_down  = m[1];
        btn_left  = m[2];
        btn_right = m[3];
        btn_enter = m[4];
        btn_clear = m[5];
        btn_new   = m[6];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return (|row_sel) | (|col_sel) | enter | clear | new_game;
    endfunction

    task automatic chk_all_zero(input string nm);
        chk({nm, "_row"}, row_sel, 0);
        chk({nm, "_col"}, col_sel, 0);
        chk({nm, "_num"}, num_in, 0);
        chk({nm, "_act"}, {enter, clear, new_game}, 0);
    endtask

    // Direction press held for 'hold' cycles: pulse at +7, and with
    // auto-repeat at +27 then every 5 while the debounced level is high.
    task automatic run_dir(input string nm, input logic [6:0] m,
                           input int hold, input logic [3:0] rexp,
                           input logic [3:0] cexp);
        int  bad;
        bit  pulse;
        bad = 0;
        set_btn(m);
        for (int c = 1; c <= hold + 12; c++) begin
            tick();
            pulse = (c == 7) ||
                    (AR && c >= 27 && ((c - 27) % 5) == 0 && c <= hold + 6);
            if (row_sel !== (pulse ? rexp : 4'b0000) ||
                col_sel !== (pulse ? cexp : 4'b0000))
                bad++;
            if (c == hold) set_btn(7'b0);
        end
        chk(nm, bad, 0);
    endtask

    typedef struct {
        logic [6:0] btn;
        logic [3:0] sw;
        int         hold;
        logic [3:0] e_row;
        logic [3:0] e_col;
        logic       e_ent;
        logic       e_new;
        logic [3:0] e_num;
        int         e_clr_at;
        int         e_np;
    } vec_t;

    vec_t v[12];

    initial begin
        int np, clr_at, multi, bad;
        int ent_at, new_at, clr_cnt;

        v[0]  = '{7'b0000010, 4'd7,  10, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'd0,  0, 1};
        v[1]  = '{7'b0001000, 4'd7,  3,  4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0,  0, 0};
        v[2]  = '{7'b0010000, 4'd3,  10, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd3,  0, 1};
        v[3]  = '{7'b0110000, 4'd9,  10, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd9,  8, 2};
        v[4]  = '{7'b0000011, 4'd5,  10, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd9,  0, 0};
        v[5]  = '{7'b0000101, 4'd5,  10, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'd9,  0, 1};
        v[6]  = '{7'b1000000, 4'd5,  10, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd9,  0, 1};
        v[7]  = '{7'b0100000, 4'd5,  10, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd9,  7, 1};
        v[8]  = '{7'b0010000, 4'd0,  10, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd0,  0, 1};
        v[9]  = '{7'b0010000, 4'd15, 10, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd15, 0, 1};
        v[10] = '{7'b0001100, 4'd5,  10, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd15, 0, 0};
        v[11] = '{7'b0001000, 4'd5,  10, 4'b0000, 4'b0010, 1'b0, 1'b0, 4'd15, 0, 1};

        reset  = 1'b1;
        sw_num = 4'd0;
        set_btn(7'b0);
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 12; i++) begin
            sw_num = v[i].sw;
            tick();
            tick();
            tick();
            set_btn(v[i].btn);
            np     = 0;
            clr_at = 0;
            multi  = 0;
            for (int c = 1; c <= v[i].hold + 10; c++) begin
                tick();
                if (any_out()) np++;
                if (clear && clr_at == 0) clr_at = c;
                if (int'(enter) + int'(clear) + int'(new_game) > 1) multi++;
                if (c == 7) begin
                    chk($sformatf("v%0d_row", i), row_sel, v[i].e_row);
                    chk($sformatf("v%0d_col", i), col_sel, v[i].e_col);
                    chk($sformatf("v%0d_enter", i), enter, v[i].e_ent);
                    chk($sformatf("v%0d_new", i), new_game, v[i].e_new);
                    chk($sformatf("v%0d_num", i), num_in, v[i].e_num);
                end
                if (c == v[i].hold) set_btn(7'b0);
            end
            chk($sformatf("v%0d_clr_at", i), clr_at, v[i].e_clr_at);
            chk($sformatf("v%0d_npulse", i), np, v[i].e_np);
            chk($sformatf("v%0d_multi", i), multi, 0);
        end

        // num_in holds across switch changes without enter
        sw_num = 4'd2;
        for (int c = 0; c < 6; c++) tick();
        chk("num_hold", num_in, 15);

        // two 3-cycle glitches separated by a short gap: no accumulation
        bad = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1 || c == 6) btn_right = 1'b1;
            if (c == 4 || c == 9) btn_right = 1'b0;
            tick();
            if (any_out()) bad++;
        end
        chk("glitch_pair", bad, 0);

        // long hold: single pulse, or repeats when auto-repeat is built in
        run_dir("hold_down50", 7'b0000010, 50, 4'b0010, 4'b0000);
        run_dir("hold_left60", 7'b0000100, 60, 4'b0000, 4'b0001);

        // new_game arrives while clear is pending: clear is flushed
        sw_num = 4'd4;
        tick();
        tick();
        tick();
        set_btn(7'b0110000);
        ent_at  = 0;
        new_at  = 0;
        clr_cnt = 0;
        multi   = 0;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (c == 1) btn_new = 1'b1;
            if (enter && ent_at == 0) ent_at = c;
            if (new_game && new_at == 0) new_at = c;
            if (clear) clr_cnt++;
            if (int'(enter) + int'(clear) + int'(new_game) > 1) multi++;
            if (c == 10) set_btn(7'b0);
        end
        chk("flush_enter_at", ent_at, 7);
        chk("flush_new_at", new_at, 8);
        chk("flush_clear_cnt", clr_cnt, 0);
        chk("flush_multi", multi, 0);
        chk("flush_num", num_in, 4);

        // reset while a pulse is on the outputs clears them at once
        set_btn(7'b0001000);
        for (int c = 1; c <= 7; c++) tick();
        chk("pre_rst_col", col_sel, 4'b0010);
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");

        // button still held through reset must debounce again from 0
        bad = 0;
        tick();
        if (any_out()) bad++;
        tick();
        if (any_out()) bad++;
        reset = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 7) begin
                if (col_sel !== 4'b0010) bad++;
            end else if (any_out()) begin
                bad++;
            end
        end
        chk("rst_redebounce", bad, 0);
        set_btn(7'b0);
        for (int c = 0; c < 12; c++) tick();
        chk("final_idle", any_out(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
